ui_debounce: RTL and testbench

//  Input conditioning stage between the ui_in pads and the core logic. Per channel:
//  - synchronises the asynchronous pin into clk,
//  - filters bounce and glitches,
//  - emits a clean level plus one-cycle rise/fall strobes.
//  Its output replaces raw ui_in bits wherever the core consumes them, e.g. the ui_in[0]
//  to uo_out[0] path.

---
 rtl/tt_io_pkg.sv | 7 +
 rtl/ui_debounce_ch.sv | 62 ++++++
 rtl/ui_debounce.sv | 41 ++++
 tb/tb_ui_debounce.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/tt_io_pkg.sv
// Shared constants for the tiny-tapeout I/O conditioning blocks.
package tt_io_pkg;

   localparam int unsigned DEFAULT_SYNC_STAGES   = 2;
   localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

endpackage : tt_io_pkg

// File: rtl/ui_debounce_ch.sv
// Single-bit input conditioner: synchroniser, stability counter, and
// debounced level with one-cycle rise/fall strobes.
module ui_debounce_ch
   import tt_io_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser chain; keeps sampling even while the filter is disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      end
   end

   // Stability filter: level flips only after s differs for STABLE_CYCLES
   // consecutive enabled cycles; the strobe is registered alongside the flip.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         level_o <= 1'b0;
         rise_o  <= 1'b0;
         fall_o  <= 1'b0;
      end else begin
         rise_o <= 1'b0;
         fall_o <= 1'b0;
         if (!ena) begin
            cnt_q <= '0;
         end else if (s == level_o) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            level_o <= s;
            cnt_q   <= '0;
            rise_o  <= s;
            fall_o  <= ~s;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule : ui_debounce_ch

// File: rtl/ui_debounce.sv
// Input conditioning for the ui_in pads: NUM_CH independent debounce channels.
module ui_debounce
   import tt_io_pkg::*;
#(
   parameter int unsigned NUM_CH        = 8,
   parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NUM_CH-1:0] raw_i,
   output logic [NUM_CH-1:0] level_o,
   output logic [NUM_CH-1:0] rise_o,
   output logic [NUM_CH-1:0] fall_o
);

   // Reject parameter values the channel logic cannot implement.
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("ui_debounce: SYNC_STAGES must be >= 2");
   end
   if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("ui_debounce: STABLE_CYCLES must be >= 1");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ui_debounce_ch #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .ena    (ena),
         .raw_i  (raw_i[i]),
         .level_o(level_o[i]),
         .rise_o (rise_o[i]),
         .fall_o (fall_o[i])
      );
   end

endmodule : ui_debounce

// File: tb/tb_ui_debounce.sv
// Directed bench for ui_debounce: default 8-channel instance plus a
// single-channel STABLE_CYCLES=1 instance.
module tb_ui_debounce;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] raw;
   logic [7:0] level, rise, fall;
   logic       raw1, level1, rise1, fall1;

   int unsigned n_checks;
   int unsigned n_pass;

   ui_debounce #(
      .NUM_CH       (8),
      .SYNC_STAGES  (2),
      .STABLE_CYCLES(4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .raw_i  (raw),
      .level_o(level),
      .rise_o (rise),
      .fall_o (fall)
   );

   ui_debounce #(
      .NUM_CH       (1),
      .SYNC_STAGES  (2),
      .STABLE_CYCLES(1)
   ) dut1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .raw_i  (raw1),
      .level_o(level1),
      .rise_o (rise1),
      .fall_o (fall1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
   endtask

   // Advance one rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance n edges, checking the outputs stay at the given values.
   task automatic hold(input int unsigned n, input string tag,
                       input logic [7:0] lv, input logic [7:0] rs, input logic [7:0] fl);
      for (int unsigned k = 0; k < n; k++) begin
         step();
         check({tag, "_lvl"}, level, lv);
         check({tag, "_rise"}, rise, rs);
         check({tag, "_fall"}, fall, fl);
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n = 1'b0;
      ena   = 1'b1;
      raw   = 8'hFF;
      raw1  = 1'b0;

      // 1. Reset holds everything at 0 despite raw high.
      hold(10, "reset", 8'h00, 8'h00, 8'h00);
      raw   = 8'h00;
      rst_n = 1'b1;
      hold(8, "idle", 8'h00, 8'h00, 8'h00);

      // 2. Clean rising edge on ch0: visible after edge 6, strobe one cycle.
      raw = 8'h01;
      hold(5, "clean_pre", 8'h00, 8'h00, 8'h00);
      hold(1, "clean_e6", 8'h01, 8'h01, 8'h00);
      hold(2, "clean_post", 8'h01, 8'h00, 8'h00);

      // Return ch0 to 0 (fall strobe at edge 6).
      raw = 8'h00;
      hold(5, "fall_pre", 8'h01, 8'h00, 8'h00);
      hold(1, "fall_e6", 8'h00, 8'h00, 8'h01);
      hold(1, "fall_post", 8'h00, 8'h00, 8'h00);

      // 3. Glitch: three cycles high never qualifies, counter clears.
      raw = 8'h01;
      hold(3, "glitch_hi", 8'h00, 8'h00, 8'h00);
      raw = 8'h00;
      hold(4, "glitch_lo", 8'h00, 8'h00, 8'h00);
      check("glitch_cnt", 8'(dut.g_ch[0].u_ch.cnt_q), 8'h00);

      // 4. Enable: count interrupted by ena=0, restarts from 0 on return.
      raw = 8'h02;
      hold(3, "ena_pre", 8'h00, 8'h00, 8'h00);
      ena = 1'b0;
      hold(5, "ena_off", 8'h00, 8'h00, 8'h00);
      ena = 1'b1;
      hold(3, "ena_on", 8'h00, 8'h00, 8'h00);
      hold(1, "ena_rise", 8'h02, 8'h02, 8'h00);
      hold(1, "ena_post", 8'h02, 8'h00, 8'h00);

      // 5. Reset mid-count with ch2 high.
      raw = 8'h06;
      hold(5, "mid_pre", 8'h02, 8'h00, 8'h00);
      hold(1, "mid_set", 8'h06, 8'h04, 8'h00);
      raw = 8'h02;
      hold(4, "mid_cnt", 8'h06, 8'h00, 8'h00);
      check("mid_cnt2", 8'(dut.g_ch[2].u_ch.cnt_q), 8'h02);
      rst_n = 1'b0;
      #1;
      check("mid_rst_lvl", level, 8'h00);
      check("mid_rst_fall", fall, 8'h00);
      check("mid_rst_cnt", 8'(dut.g_ch[2].u_ch.cnt_q), 8'h00);
      raw   = 8'h06;
      #1;
      rst_n = 1'b1;
      hold(5, "requal_pre", 8'h00, 8'h00, 8'h00);
      hold(1, "requal_e6", 8'h06, 8'h06, 8'h00);

      // 6. Simultaneous channel events.
      raw = 8'h00;
      hold(5, "clr_pre", 8'h06, 8'h00, 8'h00);
      hold(1, "clr_e6", 8'h00, 8'h00, 8'h06);
      raw = 8'hA5;
      hold(5, "simA5_pre", 8'h00, 8'h00, 8'h00);
      hold(1, "simA5_e6", 8'hA5, 8'hA5, 8'h00);
      hold(1, "simA5_post", 8'hA5, 8'h00, 8'h00);
      raw = 8'h5A;
      hold(5, "sim5A_pre", 8'hA5, 8'h00, 8'h00);
      hold(1, "sim5A_e6", 8'h5A, 8'h5A, 8'hA5);
      hold(1, "sim5A_post", 8'h5A, 8'h00, 8'h00);

      // 7. STABLE_CYCLES=1: level follows s one cycle later, every change strobes.
      raw1 = 1'b1;
      step();
      step();
      check("sc1_e2_lvl", 8'(level1), 8'h00);
      step();
      check("sc1_e3_lvl", 8'(level1), 8'h01);
      check("sc1_e3_rise", 8'(rise1), 8'h01);
      check("sc1_e3_fall", 8'(fall1), 8'h00);
      raw1 = 1'b0;
      step();
      check("sc1_e4_rise", 8'(rise1), 8'h00);
      step();
      check("sc1_e5_lvl", 8'(level1), 8'h01);
      step();
      check("sc1_e6_lvl", 8'(level1), 8'h00);
      check("sc1_e6_fall", 8'(fall1), 8'h01);
      check("sc1_e6_rise", 8'(rise1), 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_ui_debounce
